// File: rtl/or_window_accumulator_if.sv
// or_window_accumulator_if: handshake bundle for the OR window accumulator.
// Carries the input beat stream (valid/bit/ready) and the frame result stream
// (valid/bit/ready). With OR_ACC_ONES_CNT_EN defined it also carries out_ones,
// the count of 1 beats in the finished frame.
// master = producer/consumer side, slave = the accumulator itself.
`timescale 1ns/1ps

interface or_window_accumulator_if #(
    parameter int LEN = 4
);
    logic in_valid;
    logic in_bit;
    logic in_ready;
    logic out_valid;
    logic out_bit;
    logic out_ready;

`ifdef OR_ACC_ONES_CNT_EN
    logic [$clog2(LEN+1)-1:0] out_ones;

    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_bit, out_ones
    );

    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_bit, out_ones
    );
`else
    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_bit
    );

    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_bit
    );
`endif

endinterface

// File: rtl/or_window_accumulator.sv
// or_window_accumulator: collects LEN single-bit beats into a frame and
// presents the OR of the frame as one result beat with valid/ready flow.
// A two-state machine (ACC collecting, FULL result pending) sequences it.
// The result is registered on the last beat, so out_valid rises one cycle
// after that beat. While a result waits, input is stalled unless the
// consumer drains it in the same cycle, in which case the incoming beat
// starts the next frame. clear discards the partial frame only.
// Optional feature macro: OR_ACC_ONES_CNT_EN adds out_ones, the number of
// 1 beats in the frame, registered and held alongside out_bit.
`timescale 1ns/1ps

module or_window_accumulator #(
    parameter int LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    or_window_accumulator_if.slave      bus
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LEN - 1);

    typedef enum logic {
        ACC  = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] beat_cnt;
    logic             acc_bit;
    logic             out_bit_q;
    logic             in_ready;
    logic             accept;
    logic             last_beat;
    logic             frame_or;

`ifdef OR_ACC_ONES_CNT_EN
    localparam int ONES_W = $clog2(LEN + 1);

    logic [ONES_W-1:0] ones_acc;
    logic [ONES_W-1:0] ones_next;
    logic [ONES_W-1:0] out_ones_q;
`endif

    // State register; reset lands in ACC with nothing pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake decode and next-state: a frame completes on the last
    // accepted beat, and a pending result leaves FULL whenever the consumer
    // is ready, whether or not clear is also high.
    always_comb begin
        state_d   = state_q;
        in_ready  = !clear && ((state_q == ACC) || bus.out_ready);
        accept    = bus.in_valid && in_ready;
        last_beat = accept && (beat_cnt == LAST_BEAT);
        frame_or  = ((beat_cnt == '0) ? 1'b0 : acc_bit) | bus.in_bit;

        case (state_q)
            ACC: begin
                if (last_beat) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    state_d = ACC;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    // Beat counter and running OR; the first beat of a frame loads the
    // accumulator, clear empties the frame and drops any concurrent beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            acc_bit  <= 1'b0;
        end else if (clear) begin
            beat_cnt <= '0;
            acc_bit  <= 1'b0;
        end else if (accept) begin
            if (last_beat) begin
                beat_cnt <= '0;
                acc_bit  <= 1'b0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
                acc_bit  <= frame_or;
            end
        end
    end

    // Result register; only written when a frame completes, so it holds
    // steady for as long as the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bit_q <= 1'b0;
        end else if (last_beat) begin
            out_bit_q <= frame_or;
        end
    end

`ifdef OR_ACC_ONES_CNT_EN
    // Running ones count for the frame, restarted by the first beat.
    always_comb begin
        ones_next = ((beat_cnt == '0) ? '0 : ones_acc) + ONES_W'(bus.in_bit);
    end

    // Ones counter tracks the frame exactly like the OR accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_acc <= '0;
        end else if (clear) begin
            ones_acc <= '0;
        end else if (accept) begin
            if (last_beat) begin
                ones_acc <= '0;
            end else begin
                ones_acc <= ones_next;
            end
        end
    end

    // Ones result is captured together with out_bit and held with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ones_q <= '0;
        end else if (last_beat) begin
            out_ones_q <= ones_next;
        end
    end

    assign bus.out_ones = out_ones_q;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_bit   = out_bit_q;

endmodule

// File: tb/tb_or_window_accumulator.sv
// tb_or_window_accumulator: directed scenarios followed by random traffic,
// checked against a frame-level reference model (a queue of beats per frame,
// a pending-result slot). Covers OR_ACC_ONES_CNT_EN when it is defined.
`timescale 1ns/1ps

module tb_or_window_accumulator;

    localparam int LEN = 4;

    logic clk;
    logic rst_n;
    logic clear;

    int checks;
    int errors;
    int stepNo;

    bit mFrame[$];
    bit mPend;
    bit mPendBit;
    int mPendOnes;

    or_window_accumulator_if #(.LEN(LEN)) bus ();

    or_window_accumulator #(.LEN(LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s step=%0d observed=%0h expected=%0h", tag, stepNo, obs, exp);
        end
    endtask

    // Frame-level model of one rising edge.
    task automatic modelEdge(input bit cl, input bit iv, input bit ib, input bit ordy);
        bit ready;
        bit orv;
        int ones;
        ready = !cl && (!mPend || ordy);
        if (mPend && ordy) mPend = 1'b0;
        if (cl) begin
            mFrame.delete();
        end else if (iv && ready) begin
            mFrame.push_back(ib);
            if (mFrame.size() == LEN) begin
                orv  = 1'b0;
                ones = 0;
                foreach (mFrame[k]) begin
                    orv  = orv | mFrame[k];
                    ones = ones + int'(mFrame[k]);
                end
                mPend     = 1'b1;
                mPendBit  = orv;
                mPendOnes = ones;
                mFrame.delete();
            end
        end
    endtask

    task automatic checkPending();
        checkOutput("out_valid", {31'b0, bus.out_valid}, {31'b0, mPend});
        if (mPend) begin
            checkOutput("out_bit", {31'b0, bus.out_bit}, {31'b0, mPendBit});
`ifdef OR_ACC_ONES_CNT_EN
            checkOutput("out_ones", 32'(bus.out_ones), 32'(mPendOnes));
`endif
        end
    endtask

    // One cycle: drive after a falling edge, check in_ready, clock, check results.
    task automatic applyStimulus(input bit cl, input bit iv, input bit ib, input bit ordy);
        stepNo++;
        clear         = cl;
        bus.in_valid  = iv;
        bus.in_bit    = ib;
        bus.out_ready = ordy;
        #1;
        checkOutput("in_ready", {31'b0, bus.in_ready}, {31'b0, (!cl && (!mPend || ordy))});
        @(posedge clk);
        modelEdge(cl, iv, ib, ordy);
        @(negedge clk);
        checkPending();
    endtask

    // Asynchronous reset pulse fully between two clock edges.
    task automatic pulseReset();
        stepNo++;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("rst_out_bit", {31'b0, bus.out_bit}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        mFrame.delete();
        mPend = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkPending();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        stepNo        = 0;
        mPend         = 1'b0;
        mPendBit      = 1'b0;
        mPendOnes     = 0;
        rst_n         = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.out_ready = 1'b0;

        #1;
        checkOutput("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("reset_out_bit", {31'b0, bus.out_bit}, 32'd0);
        checkOutput("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
`ifdef OR_ACC_ONES_CNT_EN
        checkOutput("reset_out_ones", 32'(bus.out_ones), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Beats 0,0,1,0 with a ready consumer.
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 1, 1);
        checkOutput("d027_no_early_valid", {31'b0, bus.out_valid}, 32'd0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("d027_valid", {31'b0, bus.out_valid}, 32'd1);
        checkOutput("d027_bit", {31'b0, bus.out_bit}, 32'd1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("d027_pulse_end", {31'b0, bus.out_valid}, 32'd0);

        // All-zero frame, then all-one frame.
        for (int i = 0; i < LEN; i++) applyStimulus(0, 1, 0, 1);
        checkOutput("d028_zero_bit", {31'b0, bus.out_bit}, 32'd0);
        for (int i = 0; i < LEN; i++) applyStimulus(0, 1, 1, 1);
        checkOutput("d028_one_bit", {31'b0, bus.out_bit}, 32'd1);
`ifdef OR_ACC_ONES_CNT_EN
        checkOutput("d028_ones", 32'(bus.out_ones), 32'd4);
`endif
        applyStimulus(0, 0, 0, 1);

        // Stalled consumer, then drain with a concurrent first beat.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput("d029_hold_bit", {31'b0, bus.out_bit}, 32'd1);
        end
        applyStimulus(0, 1, 1, 1);
        checkOutput("d029_drained", {31'b0, bus.out_valid}, 32'd0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 1);
        checkOutput("d029_next_valid", {31'b0, bus.out_valid}, 32'd1);
        checkOutput("d029_next_bit", {31'b0, bus.out_bit}, 32'd1);
        applyStimulus(0, 0, 0, 1);

        // Clear discards a partial frame and the beat offered with it.
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 1, 1, 1);
        applyStimulus(1, 1, 1, 1);
        for (int i = 0; i < LEN - 1; i++) applyStimulus(0, 1, 0, 1);
        checkOutput("d030_not_yet", {31'b0, bus.out_valid}, 32'd0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("d030_valid", {31'b0, bus.out_valid}, 32'd1);
        checkOutput("d030_bit", {31'b0, bus.out_bit}, 32'd0);
        applyStimulus(0, 0, 0, 1);

        // Clear while a result waits leaves the result intact.
        for (int i = 0; i < LEN; i++) applyStimulus(0, 1, (i == 1), 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("clr_keeps_bit", {31'b0, bus.out_bit}, 32'd1);
        applyStimulus(1, 1, 0, 1);
        checkOutput("clr_drain", {31'b0, bus.out_valid}, 32'd0);

        // Reset mid-frame and again with a result pending.
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 1, 0);
        pulseReset();
        for (int i = 0; i < LEN; i++) applyStimulus(0, 1, 1, 0);
        checkOutput("d031_full", {31'b0, bus.out_valid}, 32'd1);
        pulseReset();
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 1, 1);
        checkOutput("d031_valid", {31'b0, bus.out_valid}, 32'd1);
        checkOutput("d031_bit", {31'b0, bus.out_bit}, 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulseReset();
            end else begin
                applyStimulus(($urandom_range(0, 15) == 0),
                              ($urandom_range(0, 3) != 0),
                              ($urandom_range(0, 3) == 0),
                              ($urandom_range(0, 1) == 1));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/or_window_accumulator.md
OR_WINDOW_ACCUMULATOR -- requirements
Module: or_window_accumulator

Interface
REQ-001 The block SHALL have one parameter: LEN, default 4, the number of input beats per frame (legal range 2..256).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port clear, input, 1 bit: synchronous discard of the partial frame.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the input beat is present.
REQ-006 The block SHALL have port in_bit, input, 1 bit: the input data, typically a gate or mux output.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit: a frame result is pending.
REQ-009 The block SHALL have port out_bit, output, 1 bit: the OR of all LEN beats of the frame.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.

Function
REQ-011 A beat SHALL be accepted when in_valid and in_ready are both high at a rising clk edge.
REQ-012 The state machine SHALL have states ACC (collecting a frame) and FULL (result pending); out_valid SHALL be high only in FULL.
REQ-013 The beat counter SHALL be $clog2(LEN) bits wide, SHALL increment on each accepted beat, and SHALL wrap to 0 on the LEN-th beat.
REQ-014 The first beat of a frame SHALL load the accumulator with in_bit; each later beat SHALL set it to accumulator OR in_bit.
REQ-015 On the LEN-th accepted beat, the block SHALL register out_bit as accumulator OR in_bit and move to FULL, so out_valid rises one cycle after the last beat (latency 1).
REQ-016 The block SHALL drive in_ready = !clear && (state==ACC || out_ready).
REQ-017 In FULL with out_ready high, the block SHALL clear out_valid on the next edge and return to ACC; a beat accepted in the same cycle SHALL be the first beat of the new frame.
REQ-018 out_bit SHALL hold stable while out_valid is high and out_ready is low.
REQ-019 out_ready SHALL be ignored while out_valid is low.
REQ-020 clear high SHALL zero the counter and accumulator, SHALL drop any concurrent in_valid beat, and SHALL NOT affect a pending FULL result.
REQ-021 If clear and out_ready are both high in FULL, the result SHALL be drained and the block SHALL return to ACC with an empty frame.

Reset
REQ-022 While rst_n is low, the block SHALL be in state ACC with counter=0, accumulator=0, out_valid=0, out_bit=0; in_ready SHALL follow REQ-016.
REQ-023 Reset asserted mid-frame or in FULL SHALL discard all partial and pending data immediately, without waiting for clk.
REQ-024 The first beat accepted after rst_n deasserts SHALL be beat 0 of a new frame.

Configuration
REQ-025 With macro OR_ACC_ONES_CNT_EN defined, the block SHALL add output out_ones, $clog2(LEN+1) bits wide: the count of 1 beats in the frame, registered with out_bit, held under REQ-018, reset to 0, and cleared by clear.
REQ-026 Without OR_ACC_ONES_CNT_EN, the out_ones port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 LEN=4, beats 0,0,1,0 with out_ready=1 -> out_valid pulses 1 cycle after beat 3 with out_bit=1 (out_ones=1 if enabled).
REQ-028 LEN=4, beats 0,0,0,0 -> out_bit=0; then beats 1,1,1,1 -> out_bit=1 (out_ones=4).
REQ-029 Frame done with out_ready=0 for 5 cycles -> out_valid and out_bit hold and in_ready=0; raising out_ready with in_valid=1, in_bit=1 -> drains and takes beat 0 of the next frame.
REQ-030 Two beats 1,1 then clear=1 with in_valid=1, then beats 0,0,0,0 -> single result with out_bit=0; the beat during clear is not counted.
REQ-031 rst_n pulsed low between edges mid-frame and again in FULL -> out_valid=0 at once; the next 4 beats 0,0,0,1 -> out_bit=1.
